// File: rtl/weights_sram_loader.sv
// Packs a stream of int8 weight bytes into 32-bit SRAM words, little-endian lanes.
// Optional macro WEIGHTS_LOADER_CKSUM_EN adds a 16-bit byte-sum output o_checksum.
module weights_sram_loader #(
    parameter int ADR_W  = 16,
    parameter int SRAM_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADR_W-1:0]  i_base_addr,
    input  logic [ADR_W+1:0]  i_num_bytes,
    input  logic              i_wgt_valid,
    input  logic [7:0]        i_wgt_data,
    output logic              o_wgt_ready,
    output logic [ADR_W-1:0]  o_sram_addr,
    output logic              o_sram_wren,
    output logic [SRAM_W-1:0] o_sram_wdata,
    output logic              o_busy,
`ifdef WEIGHTS_LOADER_CKSUM_EN
    output logic [15:0]       o_checksum,
`endif
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_done_phase;
    logic [1:0]         r_lane;
    logic [ADR_W+1:0]   r_remaining;
    logic [ADR_W-1:0]   r_addr;
    logic [SRAM_W-1:0]  r_pack;
    logic               r_wgt_ready;
    logic               r_sram_wren;
    logic [ADR_W-1:0]   r_sram_addr;
    logic [SRAM_W-1:0]  r_sram_wdata;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic               w_word_full;
    logic               w_last_byte;
    logic [SRAM_W-1:0]  w_pack_next;

    assign w_accept    = i_wgt_valid & r_wgt_ready;
    assign w_word_full = (r_lane == 2'd3);
    assign w_last_byte = (r_remaining == (ADR_W+2)'(1));
    // Lanes above r_lane are always zero, so OR-ing in the new byte both packs
    // the word and leaves unused upper lanes zero for a short final word.
    assign w_pack_next = r_pack | (SRAM_W'(i_wgt_data) << {r_lane, 3'b000});

    // NOTE: every register here is assigned with <= so all state updates see
    // the pre-edge values; reset is synchronous, checked first inside the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_done_phase <= 1'b0;
            r_lane       <= 2'd0;
            r_remaining  <= '0;
            r_addr       <= '0;
            r_pack       <= '0;
            r_wgt_ready  <= 1'b0;
            r_sram_wren  <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sram_wren <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_busy       <= 1'b1;
                        r_done_phase <= 1'b0;
                        if (i_num_bytes != '0) begin
                            r_state     <= ST_LOAD;
                            r_wgt_ready <= 1'b1;
                            r_addr      <= i_base_addr;
                            r_remaining <= i_num_bytes;
                            r_lane      <= 2'd0;
                            r_pack      <= '0;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (w_word_full || w_last_byte) begin
                            r_sram_wren  <= 1'b1;
                            r_sram_addr  <= r_addr;
                            r_sram_wdata <= w_pack_next;
                            r_addr       <= r_addr + 1'b1;
                            r_pack       <= '0;
                            r_lane       <= 2'd0;
                        end else begin
                            r_pack <= w_pack_next;
                            r_lane <= r_lane + 1'b1;
                        end
                        if (w_last_byte) begin
                            r_state      <= ST_DONE;
                            r_wgt_ready  <= 1'b0;
                            r_done_phase <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    // Two cycles in DONE: the first drains the final write, the second pulses o_done.
                    if (!r_done_phase) begin
                        r_done_phase <= 1'b1;
                        r_done       <= 1'b1;
                    end else begin
                        r_done_phase <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_wgt_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef WEIGHTS_LOADER_CKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_checksum <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_checksum <= '0;
        end else if ((r_state == ST_LOAD) && w_accept) begin
            r_checksum <= r_checksum + 16'(i_wgt_data);
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign o_wgt_ready  = r_wgt_ready;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wren  = r_sram_wren;
    assign o_sram_wdata = r_sram_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: doc/weights_sram_loader.md
WEIGHTS_SRAM_LOADER -- requirements
Module: weights_sram_loader

Interface
REQ-001 SHALL have parameter ADR_W, default 16, the SRAM word address width.
REQ-002 SHALL have parameter SRAM_W, default 32, the SRAM data width; only 32 is supported (4 bytes per word).
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  one-cycle load request, sampled only in IDLE.
REQ-006 SHALL have port i_base_addr  input  ADR_W  first SRAM word address, latched on start.
REQ-007 SHALL have port i_num_bytes  input  ADR_W+2  count of weight bytes to load, latched on start.
REQ-008 SHALL have port i_wgt_valid  input  1  the weight byte on i_wgt_data is valid.
REQ-009 SHALL have port i_wgt_data  input  8  signed int8 weight byte.
REQ-010 SHALL have port o_wgt_ready  output  1  the loader accepts a byte this cycle.
REQ-011 SHALL have port o_sram_addr  output  ADR_W  SRAM write word address.
REQ-012 SHALL have port o_sram_wren  output  1  SRAM write enable, one cycle per word.
REQ-013 SHALL have port o_sram_wdata  output  SRAM_W  packed weight word.
REQ-014 SHALL have port o_busy  output  1  high in LOAD and DONE.
REQ-015 SHALL have port o_done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD and DONE.
REQ-017 In IDLE, i_start with i_num_bytes!=0 SHALL latch base and count and go to LOAD; i_start with i_num_bytes==0 SHALL go to DONE with no write.
REQ-018 i_start SHALL be ignored in LOAD and DONE.
REQ-019 o_wgt_ready SHALL be 1 only in LOAD; a byte is accepted on the cycle where i_wgt_valid and o_wgt_ready are both high.
REQ-020 Accepted byte k of a word SHALL be placed in o_sram_wdata[8k+7:8k], so the first byte goes in bits [7:0].
REQ-021 The packer SHALL accept one byte per cycle, with no bubbles between words.
REQ-022 When the 4th byte of a word is accepted at cycle T, o_sram_wren SHALL be 1 at T+1, with the packed word and the current address.
REQ-023 The address SHALL start at the latched base and increment by 1 after each write, wrapping modulo 2^ADR_W.
REQ-024 When the last byte (remaining==1) is accepted at cycle T, the partial word SHALL be written at T+1 with unused upper lanes zero.
REQ-025 After the last byte at cycle T, the FSM SHALL be in DONE at T+1 with o_wgt_ready=0, and o_done=1 at T+2 before returning to IDLE.
REQ-026 o_sram_wren SHALL be 0 on every cycle other than the write cycles defined above.
REQ-027 When i_wgt_valid is low in LOAD, the FSM SHALL hold its state and count, and partial pack contents SHALL be retained.
REQ-028 o_sram_addr and o_sram_wdata SHALL be registered, with zero combinational path from any input.

Reset
REQ-029 While i_rst=1, the FSM SHALL go to IDLE and the byte lane index, remaining count and pack register SHALL clear.
REQ-030 While i_rst=1, o_wgt_ready, o_sram_wren, o_busy and o_done SHALL be 0, and o_sram_addr and o_sram_wdata SHALL be 0.
REQ-031 A reset asserted mid-LOAD SHALL abort the load with no further write and no o_done.

Configuration
REQ-032 With macro WEIGHTS_LOADER_CKSUM_EN defined, the block SHALL add output o_checksum (16 bits): the unsigned sum modulo 2^16 of all accepted bytes, treated as unsigned 8-bit.
REQ-033 With WEIGHTS_LOADER_CKSUM_EN defined, o_checksum SHALL clear on an accepted start and on reset, and SHALL be stable and valid while o_done=1.
REQ-034 Without WEIGHTS_LOADER_CKSUM_EN, the o_checksum port and the checksum logic SHALL be absent, with all other behaviour identical.

Verification
REQ-035 Base 0x0010, 8 bytes 01..08 streamed back-to-back -> writes 0x04030201 @0x0010 and 0x08070605 @0x0011; o_done exactly 2 cycles after the 8th byte.
REQ-036 Base 0x0000, 5 bytes AA,BB,CC,DD,EE -> writes 0xDDCCBBAA @0x0000 and 0x000000EE @0x0001.
REQ-037 i_num_bytes=0 with start -> zero writes, o_wgt_ready stays 0, o_done pulses 2 cycles after start.
REQ-038 Base 0xFFFF, 8 bytes with i_wgt_valid toggled every other cycle -> writes @0xFFFF then @0x0000 with correct data, and no write while the pack is incomplete.
REQ-039 i_rst asserted after 6 of 12 bytes -> all outputs 0 next cycle, no later write or done; a new start afterwards loads normally.
REQ-040 With WEIGHTS_LOADER_CKSUM_EN defined, bytes FF,FF,02 -> o_checksum=0x0200 during o_done; a start pulsed during LOAD is ignored.
